// File: rtl/red_pitaya_guitar_delay.sv
// rtl/red_pitaya_guitar_delay.sv - feedback echo stage over a circular sample buffer
// Optional feedback low-pass (tape-echo darkening) enabled by defining GUITAR_DEL_LPF_EN.
module red_pitaya_guitar_delay #(
  parameter int DW      = 14,
  parameter int AW      = 14,
  parameter int DECAY_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  input  logic [DW-1:0]        in_sample_i,
  input  logic [15:0]          conf_del_time_i,
  input  logic [DECAY_W-1:0]   conf_del_decay_i,
  input  logic                 conf_bypass_i,
  input  logic                 ovr_clr_i,
  output logic                 out_valid_o,
  output logic [DW-1:0]        out_sample_o,
  output logic                 busy_o,
  output logic                 ovr_o
);

`ifdef GUITAR_DEL_LPF_EN
  localparam int MW = DW + 2;
`else
  localparam int MW = DW;
`endif
  localparam int PW = MW + DECAY_W + 1;
  localparam logic [AW-1:0]        ADDR_MAX = '1;
  localparam logic signed [DW-1:0] SMAX     = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SMIN     = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RD, MAC, WR} state_t;
  state_t state, state_n;

  logic signed [DW-1:0] x_q;
  logic                 bypass_q;
  logic [DECAY_W-1:0]   decay_q;
  logic [AW-1:0]        time_q;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        fill;
  logic [AW-1:0]        rd_addr;
  logic [AW-1:0]        eff_time;
  logic signed [DW-1:0] ram_q;
  logic signed [DW-1:0] out_q;
  logic                 ovr;
  logic signed [DW-1:0] mem [0:(1<<AW)-1];

  logic signed [DW-1:0] tap;
  logic signed [MW-1:0] mac_in;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] prod_sh;
  logic signed [DW:0]   fb;
  logic signed [DW:0]   sum;
  logic signed [DW-1:0] sat;

`ifdef GUITAR_DEL_LPF_EN
  logic signed [MW-1:0] lp;
  logic signed [MW-1:0] lp_n;
  logic signed [MW-1:0] lp_n_q;
  logic signed [MW-1:0] diff;
`endif

  assign busy_o       = (state != IDLE);
  assign out_valid_o  = (state == WR);
  assign out_sample_o = out_q;
  assign ovr_o        = ovr;
  assign rd_addr      = wr_ptr - time_q;

  always_comb begin
    eff_time = conf_del_time_i[AW-1:0];
    if (conf_del_time_i == 16'd0)
      eff_time = AW'(1);
    else if (conf_del_time_i > 16'(ADDR_MAX))
      eff_time = ADDR_MAX;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid_i) state_n = RD;
      RD:      state_n = MAC;
      MAC:     state_n = WR;
      default: state_n = IDLE;
    endcase
  end

  // Locations not yet written since reset hold stale data, so gate them to silence.
  always_comb begin
    tap = (fill >= time_q) ? ram_q : '0;
`ifdef GUITAR_DEL_LPF_EN
    diff   = MW'(tap) - lp;
    lp_n   = lp + (diff >>> 2);
    mac_in = lp_n;
`else
    mac_in = tap;
`endif
    prod    = PW'(mac_in) * PW'($signed({1'b0, decay_q}));
    prod_sh = prod >>> DECAY_W;
    fb      = prod_sh[DW:0];
    sum     = {x_q[DW-1], x_q} + fb;
    if (sum[DW] != sum[DW-1])
      sat = sum[DW] ? SMIN : SMAX;
    else
      sat = sum[DW-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q      <= '0;
      bypass_q <= 1'b0;
      decay_q  <= '0;
      time_q   <= AW'(1);
      wr_ptr   <= '0;
      fill     <= '0;
      out_q    <= '0;
      ovr      <= 1'b0;
`ifdef GUITAR_DEL_LPF_EN
      lp       <= '0;
      lp_n_q   <= '0;
`endif
    end else begin
      if (in_valid_i && state != IDLE) ovr <= 1'b1;
      else if (ovr_clr_i)              ovr <= 1'b0;
      case (state)
        IDLE: if (in_valid_i) begin
          x_q      <= in_sample_i;
          bypass_q <= conf_bypass_i;
          decay_q  <= conf_del_decay_i;
          time_q   <= eff_time;
        end
        MAC: begin
          out_q <= bypass_q ? x_q : sat;
`ifdef GUITAR_DEL_LPF_EN
          lp_n_q <= lp_n;
`endif
        end
        WR: begin
          wr_ptr <= wr_ptr + AW'(1);
          if (fill != ADDR_MAX) fill <= fill + AW'(1);
`ifdef GUITAR_DEL_LPF_EN
          if (!bypass_q) lp <= lp_n_q;
`endif
        end
        default: ;
      endcase
    end
  end

  // Sample buffer: no reset so it maps onto block RAM; a reset during WR aborts the write.
  always_ff @(posedge clk_i) begin
    if (state == WR && !rst_i) mem[wr_ptr] <= out_q;
    if (state == RD)           ram_q <= mem[rd_addr];
  end

endmodule

// File: tb/tb_red_pitaya_guitar_delay.sv
// tb/tb_red_pitaya_guitar_delay.sv - directed self-checking bench for the echo stage
module tb_red_pitaya_guitar_delay;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [13:0] in_sample = '0;
  logic [15:0] del_time = 16'd4;
  logic [7:0]  decay = 8'd0;
  logic        bypass = 1'b0;
  logic        ovr_clr = 1'b0;
  logic        out_valid;
  logic [13:0] out_sample;
  logic        busy;
  logic        ovr;

  int n_tests = 0;
  int n_fail  = 0;
  int xs[$];
  int ex[$];
  int got, lat;

  always #5 clk = ~clk;

  red_pitaya_guitar_delay dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .in_valid_i       (in_valid),
    .in_sample_i      (in_sample),
    .conf_del_time_i  (del_time),
    .conf_del_decay_i (decay),
    .conf_bypass_i    (bypass),
    .ovr_clr_i        (ovr_clr),
    .out_valid_o      (out_valid),
    .out_sample_o     (out_sample),
    .busy_o           (busy),
    .ovr_o            (ovr)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Issue one sample and wait a bounded 6 cycles; leaves the DUT back in IDLE.
  task automatic send(input int s, output int g, output int l);
    g = 99999;
    l = -1;
    in_valid  = 1'b1;
    in_sample = 14'(s);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      if (out_valid && l < 0) begin
        l = k;
        g = int'($signed(out_sample));
      end
    end
  endtask

  task automatic run_seq(input string tag);
    for (int i = 0; i < xs.size(); i++) begin
      send(xs[i], got, lat);
      check($sformatf("%s_out[%0d]", tag, i), got, ex[i]);
      if (i == 0) check($sformatf("%s_latency", tag), lat, 3);
    end
  endtask

  initial begin
    do_reset();
    check("rst_busy", int'(busy), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_ovr", int'(ovr), 0);
    check("rst_out_sample", int'(out_sample), 0);

    // decay 0: impulse only, no echo
    decay = 8'd0; del_time = 16'd4;
    xs = {4000, 0, 0, 0, 0, 0, 0, 0, 0};
    ex = {4000, 0, 0, 0, 0, 0, 0, 0, 0};
    run_seq("dec0");

    // decay 128: halving echoes every 4 samples
    do_reset();
    decay = 8'd128; del_time = 16'd4;
    xs.delete(); ex.delete();
`ifdef GUITAR_DEL_LPF_EN
    xs = {4000, 0, 0, 0, 0};
    ex = {4000, 0, 0, 0, 500};
`else
    for (int i = 0; i < 16; i++) begin
      xs.push_back(i == 0 ? 4000 : 0);
      ex.push_back(i == 0 ? 4000 : i == 4 ? 2000 : i == 8 ? 1000 : i == 12 ? 500 : 0);
    end
`endif
    run_seq("dec128");

    // saturation, both polarities
    do_reset();
    decay = 8'd255; del_time = 16'd1;
    xs = {8000, 8000, 8000, 8000, 8000};
    ex = {8000, 8191, 8191, 8191, 8191};
    run_seq("satpos");
    do_reset();
    xs = {-8000, -8000, -8000, -8000};
    ex = {-8000, -8192, -8192, -8192};
    run_seq("satneg");

    // time 0 clamps to 1
    do_reset();
    decay = 8'd128; del_time = 16'd0;
    xs = {4000, 0, 0};
`ifdef GUITAR_DEL_LPF_EN
    ex = {4000, 500, 437};
`else
    ex = {4000, 2000, 1000};
`endif
    run_seq("time0");

    // huge time clamps to 2**AW-1: taps stay gated this early
    do_reset();
    decay = 8'd255; del_time = 16'hFFFF;
    xs = {4000, 100, -100};
    ex = {4000, 100, -100};
    run_seq("timemax");

    // bypass outputs dry but still writes the buffer
    do_reset();
    decay = 8'd255; del_time = 16'd1; bypass = 1'b1;
    xs = {1000, 500};
    ex = {1000, 500};
    run_seq("byp");
    bypass = 1'b0;
    send(0, got, lat);
`ifdef GUITAR_DEL_LPF_EN
    check("byp_echo", got, 124);
`else
    check("byp_echo", got, 498);
`endif

    // first echo at full decay (feedback low-pass changes it)
    do_reset();
    decay = 8'd255; del_time = 16'd4;
    xs = {4000, 0, 0, 0, 0};
`ifdef GUITAR_DEL_LPF_EN
    ex = {4000, 0, 0, 0, 996};
`else
    ex = {4000, 0, 0, 0, 3984};
`endif
    run_seq("echo255");

    // overrun: second consecutive strobe dropped, sticky until cleared
    do_reset();
    decay = 8'd0; del_time = 16'd1;
    in_valid = 1'b1; in_sample = 14'd111;
    @(negedge clk);
    in_sample = 14'd222;
    @(negedge clk);
    in_valid = 1'b0;
    check("ovr_set", int'(ovr), 1);
    @(negedge clk);
    check("ovr_out_valid", int'(out_valid), 1);
    check("ovr_out_first", int'($signed(out_sample)), 111);
    @(negedge clk);
    check("ovr_sticky", int'(ovr), 1);
    check("ovr_idle_busy", int'(busy), 0);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("ovr_cleared", int'(ovr), 0);
    in_valid = 1'b1; in_sample = 14'd5;
    @(negedge clk);
    ovr_clr = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; ovr_clr = 1'b0;
    check("ovr_set_wins", int'(ovr), 1);
    repeat (2) @(negedge clk);

    // reset while in MAC: no output strobe, write pointer back to 0
    do_reset();
    send(100, got, lat);
    check("abort_pre", got, 100);
    check("abort_pre_ptr", int'(dut.wr_ptr), 1);
    in_valid = 1'b1; in_sample = 14'd1234;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("abort_in_mac", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_valid0", int'(out_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_wr_ptr", int'(dut.wr_ptr), 0);
    @(negedge clk);
    check("abort_valid1", int'(out_valid), 0);
    check("abort_out_rst", int'(out_sample), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
